led_bar_monitor: RTL and testbench

Passive observer for the 16-bit LED bar driven by `bound_flasher`. It samples the bar every clock and checks that it is a thermometer code. It decodes the lit level (0..16) and tracks the rise/fall direction, reporting peaks, troughs and sequence completion as single-cycle pulses. It sits beside `bound_flasher` in system benches and on-board self-check logic, and never drives the bar.

---
 rtl/led_bar_monitor_if.sv | 24 ++
 rtl/led_bar_monitor.sv | 76 +++++++
 tb/tb_led_bar_monitor.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_bar_monitor_if.sv
// led_bar_monitor_if: LED bar sample and monitor status bundle.
// master drives the bar and clear, slave is the monitor reporting status.
interface led_bar_monitor_if #(parameter int CNT_W = 8);
  logic [15:0] led;
  logic clr;
  logic [4:0] level;
  logic [1:0] dir;
  logic turn;
  logic turn_is_peak;
  logic [4:0] turn_level;
  logic seq_done;
  logic err_shape;
  logic err_step;
  logic err_flag;
  logic [CNT_W-1:0] turn_cnt;
  modport master (
    output led, clr,
    input level, dir, turn, turn_is_peak, turn_level, seq_done, err_shape, err_step, err_flag, turn_cnt
  );
  modport slave (
    input led, clr,
    output level, dir, turn, turn_is_peak, turn_level, seq_done, err_shape, err_step, err_flag, turn_cnt
  );
endinterface

// File: rtl/led_bar_monitor.sv
// led_bar_monitor: thermometer-code checker and rise/fall tracker for a 16-LED bar.
// Optional LED_MON_STEP_CHECK_EN adds the level step-size check (err_step).
module led_bar_monitor #(parameter int CNT_W = 8) (
  input logic clk,
  input logic rst_n,
  led_bar_monitor_if.slave bus
);
  typedef enum logic [1:0] {ZERO = 2'b00, UP = 2'b01, DOWN = 2'b10} state_t;
  state_t r_state;
  logic [15:0] r_led;
  logic [4:0] r_level, r_turn_level;
  logic r_turn, r_peak, r_seq_done, r_err_shape, r_err_step, r_err_flag;
  logic [CNT_W-1:0] r_turn_cnt;
  logic [4:0] w_lvl;
  logic w_shape_ok, w_up, w_down, w_turn, w_step, w_err;
  assign w_lvl = 5'($countones(r_led));
  assign w_shape_ok = (r_led & (r_led + 16'd1)) == 16'd0;
  assign w_up = w_lvl > r_level;
  assign w_down = w_lvl < r_level;
  assign w_turn = (r_state == UP && w_down) || (r_state == DOWN && w_lvl != 5'd0 && w_up);
`ifdef LED_MON_STEP_CHECK_EN
  logic r_vld, r_prime;
  // r_prime rises once r_led has carried a real sample for one full edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_prime <= 1'b0;
    end else begin
      r_vld <= 1'b1;
      r_prime <= r_vld;
    end
  assign w_step = r_prime && ((w_lvl > r_level + 5'd1) || (r_level > w_lvl + 5'd1));
`else
  assign w_step = 1'b0;
`endif
  assign w_err = !w_shape_ok || w_step;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_led <= 16'd0;
      r_level <= 5'd0;
      r_state <= ZERO;
      r_turn <= 1'b0;
      r_peak <= 1'b0;
      r_turn_level <= 5'd0;
      r_seq_done <= 1'b0;
      r_err_shape <= 1'b0;
      r_err_step <= 1'b0;
      r_err_flag <= 1'b0;
      r_turn_cnt <= '0;
    end else begin
      r_led <= bus.led;
      r_level <= w_lvl;
      r_state <= (r_state == ZERO) ? (w_lvl != 5'd0 ? UP : ZERO) :
                 (r_state == UP) ? (w_down ? DOWN : UP) :
                 (w_lvl == 5'd0 ? ZERO : w_up ? UP : DOWN);
      r_turn <= w_turn;
      r_peak <= w_turn ? (r_state == UP) : r_peak;
      r_turn_level <= w_turn ? r_level : r_turn_level;
      r_seq_done <= r_state == DOWN && w_lvl == 5'd0;
      r_err_shape <= !w_shape_ok;
      r_err_step <= w_step;
      r_err_flag <= w_err || (r_err_flag && !bus.clr);
      r_turn_cnt <= bus.clr ? CNT_W'(w_turn) :
                    (w_turn && r_turn_cnt != '1) ? r_turn_cnt + CNT_W'(1) : r_turn_cnt;
    end
  assign bus.level = r_level;
  assign bus.dir = r_state;
  assign bus.turn = r_turn;
  assign bus.turn_is_peak = r_peak;
  assign bus.turn_level = r_turn_level;
  assign bus.seq_done = r_seq_done;
  assign bus.err_shape = r_err_shape;
  assign bus.err_step = r_err_step;
  assign bus.err_flag = r_err_flag;
  assign bus.turn_cnt = r_turn_cnt;
endmodule

// File: tb/tb_led_bar_monitor.sv
// tb_led_bar_monitor: directed and random checks of led_bar_monitor against a level-history model.
module tb_led_bar_monitor;
  localparam int CNT_W = 4;
  localparam int VW = 18 + CNT_W;
`ifdef LED_MON_STEP_CHECK_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  led_bar_monitor_if #(.CNT_W(CNT_W)) bus ();
  led_bar_monitor #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  logic [15:0] m_ledq;
  int m_edges, m_level, m_dir, m_tlevel, m_cnt;
  bit m_turn, m_peak, m_done, m_es, m_est, m_flag;

  function automatic logic [15:0] therm(input int k);
    logic [31:0] one = 32'd1;
    return 16'((one << k) - 32'd1);
  endfunction

  function automatic bit is_thermo(input logic [15:0] v);
    for (int k = 0; k <= 16; k++) if (v == therm(k)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [VW-1:0] obs_v();
    return {bus.level, bus.dir, bus.turn, bus.turn_is_peak, bus.turn_level,
            bus.seq_done, bus.err_shape, bus.err_step, bus.err_flag, bus.turn_cnt};
  endfunction

  function automatic logic [VW-1:0] exp_v();
    return {5'(m_level), 2'(m_dir), m_turn, m_peak, 5'(m_tlevel),
            m_done, m_es, m_est, m_flag, CNT_W'(m_cnt)};
  endfunction

  task automatic model_reset();
    m_ledq = 16'd0; m_edges = 0; m_level = 0; m_dir = 0; m_tlevel = 0; m_cnt = 0;
    m_turn = 0; m_peak = 0; m_done = 0; m_es = 0; m_est = 0; m_flag = 0;
  endtask

  // One clock edge: judge the previously captured bar against the level history.
  task automatic model_edge(input logic [15:0] led_in, input bit clr_in);
    int n = $countones(m_ledq);
    bit t = 1'b0;
    m_done = 1'b0;
    if (m_dir == 0) begin
      if (n > 0) m_dir = 1;
    end else if (m_dir == 1) begin
      if (n < m_level) begin t = 1; m_peak = 1; m_tlevel = m_level; m_dir = 2; end
    end else begin
      if (n == 0) begin m_dir = 0; m_done = 1; end
      else if (n > m_level) begin t = 1; m_peak = 0; m_tlevel = m_level; m_dir = 1; end
    end
    m_turn = t;
    m_es = !is_thermo(m_ledq);
    m_est = STEP_EN && m_edges >= 2 && (n - m_level > 1 || m_level - n > 1);
    m_flag = (m_es || m_est) ? 1'b1 : clr_in ? 1'b0 : m_flag;
    m_cnt = clr_in ? int'(t) : (t && m_cnt < (1 << CNT_W) - 1) ? m_cnt + 1 : m_cnt;
    m_level = n;
    m_ledq = led_in;
    m_edges++;
  endtask

  task automatic step(input logic [15:0] v, input bit c);
    bus.led = v;
    bus.clr = c;
    @(posedge clk);
    model_edge(v, c);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.led = 16'hFFFF;
    bus.clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs_v() !== '0) begin errors++; $display("FAIL reset got=%h want=0", obs_v()); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_ramp();
    for (int k = 0; k <= 17; k++) begin
      step(therm(k > 16 ? 16 : k), 1'b0);
      checks++;
      if (obs_v() !== exp_v()) begin errors++; $display("FAIL ramp k=%0d got=%h want=%h", k, obs_v(), exp_v()); end
    end
    checks++;
    if ({bus.level, bus.dir, bus.turn, bus.err_flag} !== {5'd16, 2'b01, 1'b0, 1'b0})
      begin errors++; $display("FAIL ramp_top level=%0d dir=%b turn=%b flag=%b want 16/01/0/0", bus.level, bus.dir, bus.turn, bus.err_flag); end
  endtask

  task automatic test_peak_at_full();
    int lv[$] = '{15, 15};
    foreach (lv[i]) begin
      step(therm(lv[i]), 1'b0);
      checks++;
      if (obs_v() !== exp_v()) begin errors++; $display("FAIL full_peak i=%0d got=%h want=%h", i, obs_v(), exp_v()); end
    end
    checks++;
    if ({bus.turn, bus.turn_is_peak, bus.turn_level} !== {1'b1, 1'b1, 5'd16})
      begin errors++; $display("FAIL full_peak_turn turn=%b peak=%b tl=%0d want 1/1/16", bus.turn, bus.turn_is_peak, bus.turn_level); end
    for (int k = 14; k >= -1; k--) begin
      step(therm(k < 0 ? 0 : k), 1'b0);
      checks++;
      if (obs_v() !== exp_v()) begin errors++; $display("FAIL full_fall k=%0d got=%h want=%h", k, obs_v(), exp_v()); end
    end
    checks++;
    if ({bus.seq_done, bus.dir} !== {1'b1, 2'b00})
      begin errors++; $display("FAIL full_done done=%b dir=%b want 1/00", bus.seq_done, bus.dir); end
  endtask

  task automatic test_peak();
    int lv[$] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 9, 9};
    foreach (lv[i]) begin
      step(therm(lv[i]), i == 0);
      checks++;
      if (obs_v() !== exp_v()) begin errors++; $display("FAIL peak i=%0d got=%h want=%h", i, obs_v(), exp_v()); end
    end
    checks++;
    if ({bus.turn, bus.turn_is_peak, bus.turn_level, bus.turn_cnt} !== {1'b1, 1'b1, 5'd10, CNT_W'(1)})
      begin errors++; $display("FAIL peak10 turn=%b peak=%b tl=%0d cnt=%0d want 1/1/10/1", bus.turn, bus.turn_is_peak, bus.turn_level, bus.turn_cnt); end
    step(therm(9), 1'b0);
    checks++;
    if (bus.turn !== 1'b0) begin errors++; $display("FAIL peak_width turn=%b want 0", bus.turn); end
  endtask

  task automatic test_trough();
    int lv[$] = '{8, 7, 6, 5, 6, 6};
    int fl[$] = '{5, 4, 3, 2, 1, 0, 0};
    foreach (lv[i]) begin
      step(therm(lv[i]), 1'b0);
      checks++;
      if (obs_v() !== exp_v()) begin errors++; $display("FAIL trough i=%0d got=%h want=%h", i, obs_v(), exp_v()); end
    end
    checks++;
    if ({bus.turn, bus.turn_is_peak, bus.turn_level, bus.dir} !== {1'b1, 1'b0, 5'd5, 2'b01})
      begin errors++; $display("FAIL trough5 turn=%b peak=%b tl=%0d dir=%b want 1/0/5/01", bus.turn, bus.turn_is_peak, bus.turn_level, bus.dir); end
    foreach (fl[i]) begin
      step(therm(fl[i]), 1'b0);
      checks++;
      if (obs_v() !== exp_v()) begin errors++; $display("FAIL fall i=%0d got=%h want=%h", i, obs_v(), exp_v()); end
    end
    checks++;
    if ({bus.seq_done, bus.dir} !== {1'b1, 2'b00})
      begin errors++; $display("FAIL seq_done done=%b dir=%b want 1/00", bus.seq_done, bus.dir); end
  endtask

  task automatic test_shape();
    logic [15:0] v[$] = '{16'h0005, 16'h0005, 16'h0009, 16'h0009, 16'h0003, 16'h0003, 16'h0003};
    bit c[$] = '{0, 0, 1, 0, 0, 1, 0};
    foreach (v[i]) begin
      step(v[i], c[i]);
      checks++;
      if (obs_v() !== exp_v()) begin errors++; $display("FAIL shape i=%0d got=%h want=%h", i, obs_v(), exp_v()); end
      if (i == 1) begin
        checks++;
        if ({bus.err_shape, bus.level, bus.err_flag} !== {1'b1, 5'd2, 1'b1})
          begin errors++; $display("FAIL shape05 es=%b level=%0d flag=%b want 1/2/1", bus.err_shape, bus.level, bus.err_flag); end
      end
      if (i == 2) begin
        checks++;
        if (bus.err_flag !== 1'b1) begin errors++; $display("FAIL clr_vs_err flag=%b want 1", bus.err_flag); end
      end
    end
    checks++;
    if (bus.err_flag !== 1'b0) begin errors++; $display("FAIL clr_flag flag=%b want 0", bus.err_flag); end
  endtask

  task automatic test_step();
    logic [15:0] v[$] = '{16'h0003, 16'h001F, 16'h001F};
    foreach (v[i]) begin
      step(v[i], 1'b0);
      checks++;
      if (obs_v() !== exp_v()) begin errors++; $display("FAIL step i=%0d got=%h want=%h", i, obs_v(), exp_v()); end
    end
    checks++;
    if ({bus.err_step, bus.err_flag, bus.level} !== {STEP_EN, STEP_EN, 5'd5})
      begin errors++; $display("FAIL jump est=%b flag=%b level=%0d want %b/%b/5", bus.err_step, bus.err_flag, bus.level, STEP_EN, STEP_EN); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      step(therm(i % 2 ? 5 : 6), 1'b0);
      checks++;
      if (obs_v() !== exp_v()) begin errors++; $display("FAIL b2b i=%0d got=%h want=%h", i, obs_v(), exp_v()); end
    end
    checks++;
    if (bus.turn_cnt !== CNT_W'((1 << CNT_W) - 1))
      begin errors++; $display("FAIL saturate cnt=%0d want %0d", bus.turn_cnt, (1 << CNT_W) - 1); end
  endtask

  task automatic test_midreset();
    int lv[$] = '{6, 7, 7};
    foreach (lv[i]) begin
      step(therm(lv[i]), 1'b0);
      checks++;
      if (obs_v() !== exp_v()) begin errors++; $display("FAIL pre_rst i=%0d got=%h want=%h", i, obs_v(), exp_v()); end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_v() !== '0) begin errors++; $display("FAIL async_rst got=%h want=0", obs_v()); end
    bus.led = 16'h00FF;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      step(16'h00FF, 1'b0);
      checks++;
      if (obs_v() !== exp_v()) begin errors++; $display("FAIL reprime i=%0d got=%h want=%h", i, obs_v(), exp_v()); end
    end
    checks++;
    if ({bus.dir, bus.level, bus.err_step, bus.err_flag} !== {2'b01, 5'd8, 1'b0, 1'b0})
      begin errors++; $display("FAIL reprime8 dir=%b level=%0d est=%b flag=%b want 01/8/0/0", bus.dir, bus.level, bus.err_step, bus.err_flag); end
  endtask

  task automatic test_random();
    int cur = 8;
    logic [15:0] v;
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 5) v = 16'($urandom);
      else begin
        if (r < 12) cur = $urandom_range(0, 16);
        else if (r < 55) cur = cur < 16 ? cur + 1 : cur - 1;
        else if (r < 85) cur = cur > 0 ? cur - 1 : cur;
        v = therm(cur);
      end
      step(v, $urandom_range(0, 63) == 0);
      checks++;
      if (obs_v() !== exp_v()) begin errors++; $display("FAIL random i=%0d led=%h got=%h want=%h", i, v, obs_v(), exp_v()); end
    end
  endtask

  initial begin
    bus.led = 16'd0;
    bus.clr = 1'b0;
    model_reset();
    test_reset();
    test_ramp();
    test_peak_at_full();
    test_peak();
    test_trough();
    test_shape();
    test_step();
    test_back_to_back();
    test_midreset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
